// File: rtl/tt_um_io_buffer_if.sv
// Bus bundle for the I/O buffer tile: data in/out plus the bidirectional
// control/status byte and its output-enable mask.
interface tt_um_io_buffer_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // Driver side (harness / pad ring)
    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    // Buffer side
    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_io_buffer.sv
// I/O buffer tile: selects between pass-through, a fixed-length delay line,
// a small FIFO and hold, all feeding one registered output byte.
// Status byte: [5] full, [6] empty, [7] sticky error.
module tt_um_io_buffer #(
    parameter int DEPTH = 8,
    parameter int DELAY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    tt_um_io_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_DELAY = 2'b01,
        MODE_FIFO  = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    mode_e mode;
    logic  push;
    logic  pop;
    logic  clr;
    logic  fifo_mode;

    assign mode      = mode_e'(bus.uio_in[1:0]);
    assign push      = bus.uio_in[2];
    assign pop       = bus.uio_in[3];
    assign clr       = bus.uio_in[4];
    assign fifo_mode = (mode == MODE_FIFO);

    // ena and the upper control bits carry no function in this tile
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bus.ena, bus.uio_in[7:5]};

    // ---------------- state ----------------
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic             err_reg,    err_next;
    logic [7:0]       out_reg,    out_next;
    logic [7:0]       dly_reg  [DELAY];
    logic [7:0]       dly_next [DELAY];

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Delay line: stage 0 takes the input, every later stage takes its predecessor
    generate
        for (genvar gi = 0; gi < DELAY; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                assign dly_next[gi] = bus.ui_in;
            end else begin : g_tail
                assign dly_next[gi] = dly_reg[gi-1];
            end
        end
    endgenerate

    // FIFO bookkeeping: clr wins, otherwise push/pop only act in FIFO mode.
    // A pop on a full FIFO frees the slot, so a same-edge push still lands.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        err_next    = err_reg;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            err_next    = 1'b0;
        end else if (fifo_mode) begin
            if (pop) begin
                if (empty) err_next = 1'b1;
                else       do_pop   = 1'b1;
            end
            if (push) begin
                if (!full || do_pop) do_push  = 1'b1;
                else                 err_next = 1'b1;
            end
            if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Output select, using the FIFO head as it stands before this edge
    always_comb begin
        out_next = out_reg;
        case (mode)
            MODE_PASS:  out_next = bus.ui_in;
            MODE_DELAY: out_next = dly_reg[DELAY-1];
            MODE_FIFO:  out_next = empty ? 8'h00 : mem[rd_ptr_reg];
            MODE_HOLD:  out_next = out_reg;
            default:    out_next = out_reg;
        endcase
    end

    // Control/status and output registers, cleared by the async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
            out_reg    <= 8'h00;
            for (int i = 0; i < DELAY; i++) dly_reg[i] <= 8'h00;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
            out_reg    <= out_next;
            for (int i = 0; i < DELAY; i++) dly_reg[i] <= dly_next[i];
        end
    end

    // FIFO storage has no reset; empty-gating keeps stale words invisible
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= bus.ui_in;
    end

    assign bus.uo_out  = out_reg;
    assign bus.uio_out = {err_reg, empty, full, 5'b00000};
    assign bus.uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_io_buffer.sv
// Randomised and directed bench for tt_um_io_buffer, checked against a
// queue-based reference model of the buffer's behaviour.
module tb_tt_um_io_buffer;
    localparam int DEPTH = 8;
    localparam int DELAY = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_um_io_buffer_if bus();

    tt_um_io_buffer #(.DEPTH(DEPTH), .DELAY(DELAY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [7:0] m_q[$];     // FIFO contents, head at index 0
    logic [7:0] m_hist[$];  // last DELAY inputs, oldest at index 0
    logic       m_err;
    logic [7:0] m_out;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        logic f, e;
        f = (m_q.size() == DEPTH);
        e = (m_q.size() == 0);
        return {m_err, e, f, 5'b00000};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hist.delete();
        for (int i = 0; i < DELAY; i++) m_hist.push_back(8'h00);
        m_err = 1'b0;
        m_out = 8'h00;
    endtask

    task automatic model_update(input logic [1:0] mode, input logic push, input logic pop,
                                input logic clr, input logic [7:0] d);
        case (mode)
            2'd0: m_out = d;
            2'd1: m_out = m_hist[0];
            2'd2: m_out = (m_q.size() != 0) ? m_q[0] : 8'h00;
            default: ;
        endcase
        m_hist.push_back(d);
        void'(m_hist.pop_front());
        if (clr) begin
            m_q.delete();
            m_err = 1'b0;
        end else if (mode == 2'd2) begin
            if (pop) begin
                if (m_q.size() == 0) m_err = 1'b1;
                else void'(m_q.pop_front());
            end
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_err = 1'b1;
            end
        end
    endtask

    // one clock transaction: drive at negedge, model at posedge, check at next negedge
    task automatic step(input logic [1:0] mode, input logic push, input logic pop,
                        input logic clr, input logic [7:0] d);
        bus.ui_in  = d;
        bus.uio_in = {3'b000, clr, pop, push, mode};
        @(posedge clk);
        model_update(mode, push, pop, clr, d);
        @(negedge clk);
        chk("uo_out",  bus.uo_out,  m_out);
        chk("uio_out", bus.uio_out, m_status());
        chk("uio_oe",  bus.uio_oe,  8'hE0);
        $display("txn mode=%0d push=%0b pop=%0b clr=%0b in=%02h -> out=%02h st=%02h",
                 mode, push, pop, clr, d, bus.uo_out, bus.uio_out);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        chk("rst_out", bus.uo_out, 8'h00);
        chk("rst_st",  bus.uio_out, 8'h40);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_out", bus.uo_out,  8'h00);
        chk("reset_st",  bus.uio_out, 8'h40);
        chk("reset_oe",  bus.uio_oe,  8'hE0);
        rst_n = 1'b1;

        // pass then hold
        step(2'd0, 0, 0, 0, 8'hA5);
        chk("pass_a5", bus.uo_out, 8'hA5);
        step(2'd3, 0, 0, 0, 8'h00);
        chk("hold_a5", bus.uo_out, 8'hA5);

        // delay ramp from reset
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(2'd1, 0, 0, 0, 8'(i));
            chk("delay_ramp", bus.uo_out, (i <= DELAY) ? 8'h00 : 8'(i - DELAY));
        end

        // fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step(2'd2, 1, 0, 0, 8'(10 + i));
        chk("fill_full", bus.uio_out, 8'h20);
        step(2'd2, 1, 0, 0, 8'hFF);
        chk("ovf_err", bus.uio_out, 8'hA0);
        for (int i = 0; i < DEPTH; i++) begin
            step(2'd2, 0, 1, 0, 8'h00);
            chk("drain_order", bus.uo_out, 8'(10 + i));
        end
        step(2'd2, 0, 0, 0, 8'h00);
        chk("drain_empty_out", bus.uo_out, 8'h00);
        chk("drain_empty_st",  bus.uio_out, 8'hC0);

        // wrap
        step(2'd0, 0, 0, 1, 8'h00);
        chk("clr_st", bus.uio_out, 8'h40);
        for (int i = 0; i < 5; i++) step(2'd2, 1, 0, 0, 8'(8'h30 + i));
        for (int i = 0; i < 5; i++) step(2'd2, 0, 1, 0, 8'h00);
        for (int i = 0; i < 6; i++) step(2'd2, 1, 0, 0, 8'(8'h50 + i));
        for (int i = 0; i < 6; i++) begin
            step(2'd2, 0, 1, 0, 8'h00);
            chk("wrap_order", bus.uo_out, 8'(8'h50 + i));
        end
        chk("wrap_noerr", bus.uio_out, 8'h40);

        // boundaries: push+pop when full, pop when empty, clr
        for (int i = 0; i < DEPTH; i++) step(2'd2, 1, 0, 0, 8'(8'h70 + i));
        step(2'd2, 1, 1, 0, 8'hEE);
        chk("full_pushpop", bus.uio_out, 8'h20);
        for (int i = 0; i < DEPTH; i++) step(2'd2, 0, 1, 0, 8'h00);
        step(2'd2, 0, 1, 0, 8'h00);
        chk("pop_empty_err", bus.uio_out, 8'hC0);
        step(2'd2, 1, 1, 1, 8'h99);
        chk("clr_override", bus.uio_out, 8'h40);

        // async reset mid-burst, between edges
        for (int i = 0; i < 3; i++) step(2'd2, 1, 0, 0, 8'(8'h90 + i));
        step(2'd0, 0, 0, 0, 8'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out", bus.uo_out,  8'h00);
        chk("async_st",  bus.uio_out, 8'h40);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic [1:0] md;
            int r;
            r  = $urandom_range(0, 9);
            md = (r < 5) ? 2'd2 : 2'($urandom_range(0, 3));
            step(md, 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tt_um_io_buffer.md
TT_UM_IO_BUFFER -- requirements
Module: tt_um_io_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries, power of 2, legal range 2..64.
REQ-002 SHALL have parameter DELAY, default 4: delay-line length in cycles, legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port ena, input, 1 bit: always 1 when powered; ignored.
REQ-006 SHALL have port ui_in, input, 8 bits: data in.
REQ-007 SHALL have port uo_out, output, 8 bits: registered data out.
REQ-008 SHALL have port uio_in, input, 8 bits: [1:0] mode, [2] push, [3] pop, [4] clr; [7:5] ignored.
REQ-009 SHALL have port uio_out, output, 8 bits: [5] full, [6] empty, [7] err; [4:0] driven 0.
REQ-010 SHALL have port uio_oe, output, 8 bits: constant 8'hE0.

Function
REQ-011 SHALL decode mode as 00 PASS, 01 DELAY, 10 FIFO, 11 HOLD, sampled every cycle.
REQ-012 PASS: uo_out SHALL load ui_in each edge (1-cycle latency).
REQ-013 Delay line: DELAY-entry shift register SHALL shift in ui_in every cycle in all modes.
REQ-014 DELAY: uo_out SHALL load the oldest delay-line entry, i.e. ui_in sampled DELAY edges earlier; total latency DELAY+1 cycles.
REQ-015 HOLD: uo_out SHALL retain its value.
REQ-016 FIFO: uo_out SHALL load the head entry (pre-edge state) if not empty, else 8'h00.
REQ-017 FIFO storage SHALL be DEPTH x 8 with rd/wr pointers wrapping modulo DEPTH and a count of width clog2(DEPTH)+1.
REQ-018 Push and pop SHALL act only in FIFO mode; both are level-sampled, one operation per edge while high.
REQ-019 Push with count<DEPTH SHALL write ui_in at wr_ptr and advance wr_ptr.
REQ-020 Push with count==DEPTH and no pop SHALL drop the data and set err.
REQ-021 Pop with count>0 SHALL advance rd_ptr.
REQ-022 Pop with count==0 SHALL set err; a simultaneous push SHALL still write.
REQ-023 Simultaneous push and pop with 0<count<=DEPTH SHALL both succeed; count unchanged.
REQ-024 full SHALL equal (count==DEPTH); empty SHALL equal (count==0); both derived from registered count.
REQ-025 err SHALL be sticky until clr or reset.
REQ-026 clr high (any mode) SHALL zero pointers, count, and err at that edge; clr SHALL override push/pop in the same cycle.
REQ-027 FIFO contents and pointers SHALL persist across mode changes; the delay line SHALL be unaffected by clr.

Reset
REQ-028 rst_n low SHALL immediately force uo_out=0, pointers=0, count=0, err=0, and all delay-line entries=0.
REQ-029 After reset: uio_out=8'h40 (empty=1, full=0, err=0).
REQ-030 FIFO memory contents need not reset; they SHALL never be visible while empty.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight data; the first edge after release SHALL behave as from reset state.

Verification
REQ-032 PASS: ui_in=8'hA5 at edge k -> uo_out=8'hA5 after edge k; mode change to HOLD with ui_in=8'h00 -> uo_out stays 8'hA5.
REQ-033 DELAY (DELAY=4): after reset, ramp ui_in 1,2,3,... -> uo_out=0 for the first 4 edges, then 1,2,3 in order.
REQ-034 FIFO fill: push 8 values 10..17 -> full=1 after 8th edge; 9th push of 8'hFF -> err=1, contents unchanged; 8 pops -> uo_out 10..17 in order, then empty=1, uo_out=0.
REQ-035 Wrap: push 5, pop 5, push 6, pop 6 (DEPTH=8) -> order preserved across pointer wrap; err=0.
REQ-036 Boundary: simultaneous push+pop when full -> count stays 8, no err; pop when empty -> err=1; clr -> err=0, empty=1.
REQ-037 Async reset asserted mid-burst between edges -> outputs zero without a clock edge; uio_out=8'h40.
